// File: rtl/result_reader.sv
// result_reader
//   Avalon-MM read master that walks the result area written by the checker.
//   Each result record is two memory words:
//     word0 = result[23:8]
//     word1 = {result[7:0], meta[7:0]}   meta[7] = RUN, meta[0] = fail
//   Every record with RUN set is pushed to the output FIFO as
//   {fail, result_vector}. The scan stops at the first record without RUN,
//   or when a nonzero record limit is reached.
//
// Optional feature (macro RESULT_READER_CLEAR_EN):
//   After each push, the record's second word is rewritten with its meta
//   byte cleared. This consumes the record, so a later scan stops at it.
//   Without the macro the memory is never written and mem_write stays 0.
//
// Ports:
//   clock, reset_n       system clock, asynchronous active-low reset
//   start                pulse; begins a scan when idle
//   base_address         first record address, sampled on accepted start
//   max_records          record limit, sampled on accepted start (0 = none)
//   busy, done           scan in progress / one-cycle end-of-scan pulse
//   record_count         records emitted in the current or last scan
//   fail_count           emitted records with the fail bit set
//   mem_*                Avalon-MM master toward the memory arbiter
//   ofifo_data/wrreq     output FIFO write port, ofifo_full back-pressure
module result_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RTF_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_address,
    input  logic [CNT_WIDTH-1:0]    max_records,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    record_count,
    output logic [CNT_WIDTH-1:0]    fail_count,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    input  logic [DATA_WIDTH-1:0]   mem_readdata,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_writedata,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    input  logic                    mem_waitrequest,
    output logic [RTF_WIDTH:0]      ofifo_data,
    output logic                    ofifo_wrreq,
    input  logic                    ofifo_full
);

    // Low part of the result vector carried in the upper half of word1;
    // the lower half of word1 is the meta byte.
    localparam int LO_BITS   = RTF_WIDTH - DATA_WIDTH;
    localparam int META_BITS = DATA_WIDTH - LO_BITS;
    localparam int RUN_BIT   = META_BITS - 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_PUSH,
`ifdef RESULT_READER_CLEAR_EN
        ST_CLEAR,
`endif
        ST_FINISH
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   address_reg, address_next;
    logic [CNT_WIDTH-1:0]    limit_reg, limit_next;
    logic [CNT_WIDTH-1:0]    record_count_reg, record_count_next;
    logic [CNT_WIDTH-1:0]    fail_count_reg, fail_count_next;
    logic [DATA_WIDTH-1:0]   hi_word_reg, hi_word_next;
    logic [DATA_WIDTH-1:0]   lo_word_reg, lo_word_next;

    logic [CNT_WIDTH-1:0]    record_count_inc;
    logic [CNT_WIDTH-1:0]    fail_count_inc;
    logic                    limit_hit;

    // Meta bits between RUN and fail carry no meaning for this block.
    logic                    unused_meta_bits;
    assign unused_meta_bits = ^lo_word_reg[RUN_BIT:1];

    // Saturating increments: once all-ones the counters stay there while
    // the scan carries on.
    assign record_count_inc = (record_count_reg == '1) ? record_count_reg
                                                       : record_count_reg + CNT_ONE;
    assign fail_count_inc   = (fail_count_reg == '1) ? fail_count_reg
                                                     : fail_count_reg + CNT_ONE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            address_reg      <= '0;
            limit_reg        <= '0;
            record_count_reg <= '0;
            fail_count_reg   <= '0;
            hi_word_reg      <= '0;
            lo_word_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            address_reg      <= address_next;
            limit_reg        <= limit_next;
            record_count_reg <= record_count_next;
            fail_count_reg   <= fail_count_next;
            hi_word_reg      <= hi_word_next;
            lo_word_reg      <= lo_word_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        address_next      = address_reg;
        limit_next        = limit_reg;
        record_count_next = record_count_reg;
        fail_count_next   = fail_count_reg;
        hi_word_next      = hi_word_reg;
        lo_word_next      = lo_word_reg;
        busy              = 1'b0;
        done              = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_address       = address_reg;
        mem_writedata     = '0;
        ofifo_wrreq       = 1'b0;
        limit_hit         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    address_next      = base_address;
                    limit_next        = max_records;
                    record_count_next = '0;
                    fail_count_next   = '0;
                    state_next        = ST_RD_HI;
                end
            end

            ST_RD_HI: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    hi_word_next = mem_readdata;
                    address_next = address_reg + ADDR_ONE;
                    state_next   = ST_RD_LO;
                end
            end

            ST_RD_LO: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    lo_word_next = mem_readdata;
                    address_next = address_reg + ADDR_ONE;
                    // A record without RUN terminates the result area.
                    state_next   = mem_readdata[RUN_BIT] ? ST_PUSH : ST_FINISH;
                end
            end

            ST_PUSH: begin
                busy        = 1'b1;
                ofifo_wrreq = !ofifo_full;
                if (!ofifo_full) begin
                    record_count_next = record_count_inc;
                    if (lo_word_reg[0]) begin
                        fail_count_next = fail_count_inc;
                    end
                    limit_hit = (limit_reg != '0) && (record_count_inc == limit_reg);
`ifdef RESULT_READER_CLEAR_EN
                    state_next = ST_CLEAR;
`else
                    state_next = limit_hit ? ST_FINISH : ST_RD_HI;
`endif
                end
            end

`ifdef RESULT_READER_CLEAR_EN
            ST_CLEAR: begin
                busy          = 1'b1;
                mem_write     = 1'b1;
                // address already points past the record; word1 is one back.
                mem_address   = address_reg - ADDR_ONE;
                mem_writedata = {lo_word_reg[DATA_WIDTH-1 -: LO_BITS], {META_BITS{1'b0}}};
                if (!mem_waitrequest) begin
                    // record_count already holds the post-push value here.
                    limit_hit  = (limit_reg != '0) && (record_count_reg == limit_reg);
                    state_next = limit_hit ? ST_FINISH : ST_RD_HI;
                end
            end
`endif

            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ofifo_data     = {lo_word_reg[0], hi_word_reg, lo_word_reg[DATA_WIDTH-1 -: LO_BITS]};
    assign mem_byteenable = '1;
    assign record_count   = record_count_reg;
    assign fail_count     = fail_count_reg;

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader
//   Scoreboard bench for result_reader. Stimulus tasks push the expected
//   read addresses, FIFO words and (with RESULT_READER_CLEAR_EN) clear writes
//   into queues; a monitor on the falling clock edge models the Avalon slave
//   and the FIFO back-pressure, and pops/compares each transfer the DUT makes.
module tb_result_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_address = '0;
    logic [15:0] max_records = '0;
    logic        busy, done;
    logic [15:0] record_count, fail_count;
    logic [19:0] mem_address;
    logic        mem_read, mem_write;
    logic [15:0] mem_readdata = '0;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic [24:0] ofifo_data;
    logic        ofifo_wrreq;
    logic        ofifo_full = 1'b0;

    result_reader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .base_address   (base_address),
        .max_records    (max_records),
        .busy           (busy),
        .done           (done),
        .record_count   (record_count),
        .fail_count     (fail_count),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_readdata   (mem_readdata),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_waitrequest(mem_waitrequest),
        .ofifo_data     (ofifo_data),
        .ofifo_wrreq    (ofifo_wrreq),
        .ofifo_full     (ofifo_full)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] mem [logic [19:0]];
    logic [19:0] exp_rd_q [$];
    logic [24:0] exp_fifo_q [$];
    logic [35:0] exp_wr_q [$];

    int stall_n = 0, wait_left = 0;
    int full_n = 0, full_left = 0;
    int done_count = 0;
    logic        hold_pending = 1'b0;
    logic [21:0] hold_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] memrd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Slave model and monitor. Inputs are driven first, then outputs are
    // sampled 1 time unit later for the transfer that the next rising
    // edge will complete.
    always @(negedge clock) begin
        logic in_push;
        logic [19:0] ea;
        logic [24:0] ef;
        logic [35:0] ew;
        mem_readdata = memrd(mem_address);
        if ((mem_read || mem_write) && wait_left > 0) begin
            mem_waitrequest = 1'b1;
            wait_left--;
        end else begin
            mem_waitrequest = 1'b0;
        end
        in_push = busy && !mem_read && !mem_write;
        if (in_push && full_left > 0) begin
            ofifo_full = 1'b1;
            full_left--;
        end else begin
            ofifo_full = 1'b0;
        end
        #1;
        if (hold_pending)
            check("hold_stable", {mem_read, mem_write, mem_address}, hold_val);
        hold_pending = (mem_read || mem_write) && mem_waitrequest;
        hold_val = {mem_read, mem_write, mem_address};

        if (mem_read && !mem_waitrequest) begin
            if (exp_rd_q.size() == 0) begin
                check("rd_unexpected", {1'b1, mem_address}, 0);
            end else begin
                ea = exp_rd_q.pop_front();
                check("rd_addr", mem_address, ea);
            end
            wait_left = stall_n;
        end
        if (mem_write && !mem_waitrequest) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", {1'b1, mem_address, mem_writedata}, 0);
            end else begin
                ew = exp_wr_q.pop_front();
                check("wr_addr_data", {mem_address, mem_writedata}, ew);
            end
            mem[mem_address] = mem_writedata;
            wait_left = stall_n;
        end
        if (ofifo_wrreq) begin
            check("wrreq_while_full", ofifo_full, 0);
            if (exp_fifo_q.size() == 0) begin
                check("fifo_unexpected", {1'b1, ofifo_data}, 0);
            end else begin
                ef = exp_fifo_q.pop_front();
                $display("fifo write %07h expected %07h", ofifo_data, ef);
                check("fifo_data", ofifo_data, ef);
            end
            full_left = full_n;
        end
        if (done) begin
            done_count++;
            check("busy_low_at_done", busy, 0);
        end
    end

    task automatic put_rec(input logic [19:0] a, input logic [23:0] vec, input logic [7:0] meta);
        logic [19:0] a1;
        a1 = a + 20'd1;
        mem[a]  = vec[23:8];
        mem[a1] = {vec[7:0], meta};
    endtask

    task automatic load_mem();
        mem.delete();
        put_rec(20'h00100, 24'h123456, 8'h80);
        put_rec(20'h00102, 24'hABCDEF, 8'h81);
        put_rec(20'h00104, 24'h5A5A5A, 8'h80);
        mem[20'h00106] = 16'h0000;
        mem[20'h00107] = 16'h0000;
    endtask

    task automatic expect_record(input logic [19:0] a, input logic [24:0] fifo_word);
        logic [19:0] a1;
        a1 = a + 20'd1;
        exp_rd_q.push_back(a);
        exp_rd_q.push_back(a1);
        exp_fifo_q.push_back(fifo_word);
`ifdef RESULT_READER_CLEAR_EN
        exp_wr_q.push_back({a1, fifo_word[7:0], 8'h00});
`endif
    endtask

    task automatic expect_term(input logic [19:0] a);
        logic [19:0] a1;
        a1 = a + 20'd1;
        exp_rd_q.push_back(a);
        exp_rd_q.push_back(a1);
    endtask

    task automatic set_stalls(input int s, input int f);
        stall_n = s; wait_left = s;
        full_n = f;  full_left = f;
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_rd_left"}, exp_rd_q.size(), 0);
        check({tag, "_fifo_left"}, exp_fifo_q.size(), 0);
        check({tag, "_wr_left"}, exp_wr_q.size(), 0);
    endtask

    task automatic pulse_start(input logic [19:0] base, input logic [15:0] lim);
        @(negedge clock);
        base_address = base;
        max_records  = lim;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_count == prev && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("done_once", done_count, prev + 1);
    endtask

    task automatic run_scan(input string tag, input logic [19:0] base, input logic [15:0] lim);
        int prev;
        prev = done_count;
        pulse_start(base, lim);
        wait_done(prev);
        check({tag, "_busy_idle"}, busy, 0);
        check_queues(tag);
        $display("scan %s: records=%0d fails=%0d", tag, record_count, fail_count);
    endtask

    initial begin
        int  prev;
        logic found;

        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_wrreq", ofifo_wrreq, 0);
        check("rst_record_count", record_count, 0);
        check("rst_fail_count", fail_count, 0);
        check("byteenable", mem_byteenable, 2'b11);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: three records then terminator, no limit, no stalls.
        load_mem();
        set_stalls(0, 0);
        expect_record(20'h00100, 25'h0123456);
        expect_record(20'h00102, 25'h1ABCDEF);
        expect_record(20'h00104, 25'h05A5A5A);
        expect_term(20'h00106);
        run_scan("nolimit", 20'h00100, 16'd0);
        check("nolimit_records", record_count, 3);
        check("nolimit_fails", fail_count, 1);

        // 2: limit of two; third record never read.
        load_mem();
        expect_record(20'h00100, 25'h0123456);
        expect_record(20'h00102, 25'h1ABCDEF);
        run_scan("limit2", 20'h00100, 16'd2);
        check("limit2_records", record_count, 2);
        check("limit2_fails", fail_count, 1);

        // 3: waitrequest 4 cycles per access, FIFO full 5 cycles per push.
        load_mem();
        set_stalls(4, 5);
        expect_record(20'h00100, 25'h0123456);
        expect_record(20'h00102, 25'h1ABCDEF);
        expect_record(20'h00104, 25'h05A5A5A);
        expect_term(20'h00106);
        run_scan("stall", 20'h00100, 16'd0);
        check("stall_records", record_count, 3);
        check("stall_fails", fail_count, 1);
        set_stalls(0, 0);

        // 4: address wrap at the top of memory.
        mem.delete();
        mem[20'hFFFFE] = 16'hC0FF;
        mem[20'hFFFFF] = 16'hEE81;
        mem[20'h00000] = 16'h0000;
        mem[20'h00001] = 16'h0000;
        expect_record(20'hFFFFE, 25'h1C0FFEE);
        expect_term(20'h00000);
        run_scan("wrap", 20'hFFFFE, 16'd0);
        check("wrap_records", record_count, 1);
        check("wrap_fails", fail_count, 1);

        // 5: asynchronous reset during RD_LO of the second record.
        load_mem();
        prev = done_count;
        exp_rd_q.push_back(20'h00100);
        exp_rd_q.push_back(20'h00101);
        exp_rd_q.push_back(20'h00102);
        exp_fifo_q.push_back(25'h0123456);
`ifdef RESULT_READER_CLEAR_EN
        exp_wr_q.push_back({20'h00101, 8'h56, 8'h00});
`endif
        pulse_start(20'h00100, 16'd0);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock);
            #2;
            if (mem_read && mem_address == 20'h00103) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_rd_lo2", found, 1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_read", mem_read, 0);
        check("arst_wrreq", ofifo_wrreq, 0);
        check("arst_record_count", record_count, 0);
        check("arst_fail_count", fail_count, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("arst_no_done", done_count, prev);
        check_queues("arst");
        load_mem();
        expect_record(20'h00100, 25'h0123456);
        expect_record(20'h00102, 25'h1ABCDEF);
        expect_record(20'h00104, 25'h05A5A5A);
        expect_term(20'h00106);
        run_scan("rescan", 20'h00100, 16'd0);
        check("rescan_records", record_count, 3);
        check("rescan_fails", fail_count, 1);

`ifdef RESULT_READER_CLEAR_EN
        // 6: two records consumed by the clear writes, then a rescan stops.
        mem.delete();
        put_rec(20'h00100, 24'h123456, 8'h80);
        put_rec(20'h00102, 24'hABCDEF, 8'h81);
        mem[20'h00104] = 16'h0000;
        mem[20'h00105] = 16'h0000;
        expect_record(20'h00100, 25'h0123456);
        expect_record(20'h00102, 25'h1ABCDEF);
        expect_term(20'h00104);
        run_scan("clear", 20'h00100, 16'd0);
        check("clear_records", record_count, 2);
        check("clear_word1", memrd(20'h00101), 16'h5600);
        check("clear_word3", memrd(20'h00103), 16'hEF00);
        expect_term(20'h00100);
        run_scan("cleared", 20'h00100, 16'd0);
        check("cleared_records", record_count, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Avalon-MM read master that walks the result area written by the checker and unpacks each 2-word result record.
- Pushes the 24-bit result vector plus its pass/fail flag into an output FIFO toward the host link.
- Keeps running record and failure counts.
- Sits between mem_if (shared via the memory arbiter) and the host/UART transmit path.

Parameters:
- ADDR_WIDTH, 20, memory word address width
- DATA_WIDTH, 16, memory data width; RTF_WIDTH must equal DATA_WIDTH*3/2
- RTF_WIDTH, 24, result vector width
- CNT_WIDTH, 16, width of record and fail counters and of max_records

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a scan when idle
- base_address  in  ADDR_WIDTH  first record address, sampled on accepted start
- max_records  in  CNT_WIDTH  record limit, sampled on accepted start; 0 = no limit
- busy  out  1  high from the cycle after an accepted start until the scan ends
- done  out  1  single-cycle pulse when a scan ends
- record_count  out  CNT_WIDTH  records emitted in the current or last scan
- fail_count  out  CNT_WIDTH  emitted records with the fail bit set
- mem_address  out  ADDR_WIDTH  Avalon address
- mem_read  out  1  Avalon read
- mem_readdata  in  DATA_WIDTH  Avalon read data, valid when mem_read && !mem_waitrequest
- mem_write  out  1  Avalon write (only with the optional feature; otherwise tied 0)
- mem_writedata  out  DATA_WIDTH  Avalon write data
- mem_byteenable  out  DATA_WIDTH/8  all ones
- mem_waitrequest  in  1  Avalon stall
- ofifo_data  out  RTF_WIDTH+1  {fail, result_vector}
- ofifo_wrreq  out  1  FIFO write strobe
- ofifo_full  in  1  FIFO full

Behaviour:
- Reset values:
  - state IDLE; busy, done, mem_read, mem_write, ofifo_wrreq = 0
  - address, record_count, fail_count, hi_word, lo_word = 0
- Record format at addresses A and A+1:
  - word0 = result[23:8]
  - word1 = {result[7:0], meta[7:0]}
  - meta[7] = RUN (valid record); meta[0] = fail
- State machine:
  - IDLE: on start, load address, limit and the counters (cleared to 0), then go to RD_HI. A start while busy is ignored.
  - RD_HI: mem_read=1, mem_address=address. Hold until !mem_waitrequest, then latch hi_word, address+1, go to RD_LO.
  - RD_LO: same handshake; latch lo_word, address+1.
    - If mem_readdata[7]=0 (no RUN), go to FINISH; nothing is pushed.
    - Otherwise go to PUSH.
  - PUSH: ofifo_data = {lo_word[0], hi_word, lo_word[15:8]}. ofifo_wrreq=1 only when !ofifo_full; stay in PUSH while full. On the write cycle:
    - record_count+1; fail_count+1 if the fail bit is set.
    - If the new record_count equals a nonzero limit, go to FINISH; else go to RD_HI.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Read latency: one record costs at least 3 cycles (RD_HI, RD_LO, PUSH) with zero waitrequest.
- Address wraps modulo 2^ADDR_WIDTH; there is no wrap error.
- Counters saturate at all-ones; the scan continues.
- mem_read, mem_address and mem_write are held stable while mem_waitrequest=1.
- An asynchronous reset mid-scan aborts the scan: no done pulse, counters cleared.
- mem_readdata is ignored outside an accepted read cycle.

Optional Feature:
- Macro RESULT_READER_CLEAR_EN.
- When defined:
  - After PUSH, enter state CLEAR before the next RD_HI or FINISH.
  - CLEAR drives mem_write=1, mem_address=address-1, mem_writedata={lo_word[15:8], 8'h00}, held until !mem_waitrequest.
  - This consumes the record so a rescan stops at it.
- When undefined: no CLEAR state, mem_write tied 0, memory untouched.

Test Plan:
- 3 records at 0x00100 (meta 0x80, 0x81, 0x80), then 0x0000 at word 0x00107, max_records=0, no stalls:
  - 3 FIFO writes: {0,vec0}, {1,vec1}, {0,vec2}
  - record_count=3, fail_count=1, one done pulse, busy low after it
- Same memory, max_records=2: exactly 2 FIFO writes; done follows the second push; the third record is never read.
- mem_waitrequest high for 4 cycles on each read, ofifo_full high for 5 cycles in PUSH:
  - address and read held stable while stalled
  - no duplicate or lost records
  - ofifo_wrreq never asserted while full
- base_address=0xFFFFE with a valid record spanning 0xFFFFE..0xFFFFF and a terminator at 0x00000: 1 record emitted; next reads at 0x00000/0x00001; done.
- reset_n pulsed low during RD_LO of the 2nd record: outputs return to reset values immediately; a new start rescans from its base cleanly.
- With RESULT_READER_CLEAR_EN, 2 records scanned:
  - writes to 0x00101 and 0x00103 with low byte 0x00
  - a second scan of the same base emits 0 records and record_count=0
